// File: rtl/microwave_controller_pkg.sv
// Shared state encoding, BCD limits and keypad decode helpers for the
// microwave controller.
package microwave_controller_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_FIVE = 4'd5;
  localparam logic [3:0] BCD_NINE = 4'd9;

  function automatic logic is_one_hot(input logic [9:0] kp);
    int unsigned count;
    count = 0;
    for (int i = 0; i < 10; i++) begin
      if (kp[i]) count++;
    end
    return (count == 1);
  endfunction

  function automatic logic [3:0] one_hot_to_digit(input logic [9:0] kp);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (kp[i]) d = 4'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/microwave_controller_bcd_timer3.sv
// Three-digit M:SS BCD time register: shift-in of a new digit, one-second
// decrement with BCD borrow, and zero / last-second detection.
module bcd_timer3
  import microwave_controller_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       load_zero,
  input  logic       shift_en,
  input  logic [3:0] digit,
  input  logic       dec_en,
  output logic [3:0] min_digit,
  output logic [3:0] tens_digit,
  output logic [3:0] ones_digit,
  output logic       zero,
  output logic       one_left
);

  logic [3:0] min_reg;
  logic [3:0] tens_reg;
  logic [3:0] ones_reg;

  always_ff @(posedge clock) begin
    if (clear || load_zero) begin
      min_reg  <= 4'd0;
      tens_reg <= 4'd0;
      ones_reg <= 4'd0;
    end else if (shift_en) begin
      min_reg  <= tens_reg;
      tens_reg <= ones_reg;
      ones_reg <= digit;
    end else if (dec_en && !zero) begin
      // Guarded by !zero so 0:00 never wraps the minute digit.
      if (ones_reg != 4'd0) begin
        ones_reg <= ones_reg - 4'd1;
      end else if (tens_reg != 4'd0) begin
        ones_reg <= BCD_NINE;
        tens_reg <= tens_reg - 4'd1;
      end else begin
        ones_reg <= BCD_NINE;
        tens_reg <= BCD_FIVE;
        min_reg  <= min_reg - 4'd1;
      end
    end
  end

  assign min_digit  = min_reg;
  assign tens_digit = tens_reg;
  assign ones_digit = ones_reg;
  assign zero       = (min_reg == 4'd0) && (tens_reg == 4'd0) && (ones_reg == 4'd0);
  assign one_left   = (min_reg == 4'd0) && (tens_reg == 4'd0) && (ones_reg == 4'd1);

endmodule

// File: rtl/microwave_controller.sv
// Microwave oven controller: button/keypad edge detection, cooking FSM and
// registered magnetron/done outputs around a BCD countdown timer.
module microwave_controller
  import microwave_controller_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       tick_1hz,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic [3:0] min_bcd,
  output logic [3:0] secs_tens_bcd,
  output logic [3:0] secs_ones_bcd,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  state_t     state_reg;
  logic       mag_on_reg;
  logic       done_reg;
  logic       startn_prev;
  logic       stopn_prev;
  logic [9:0] keypad_prev;

  logic       start_ev;
  logic       stop_ev;
  logic       key_ev;
  logic [3:0] key_digit;
  logic       edit_state;
  logic       do_clear;
  logic       do_shift;
  logic       new_nonzero;
  logic       go_cook;
  logic       pause_now;
  logic       do_dec;
  logic       finish;
  logic       zero;
  logic       one_left;

  always_comb begin
    start_ev    = startn_prev & ~startn;
    stop_ev     = stopn_prev & ~stopn;
    key_ev      = (keypad_prev == 10'd0) && is_one_hot(keypad);
    key_digit   = one_hot_to_digit(keypad);
    edit_state  = (state_reg == IDLE) || (state_reg == ENTRY) || (state_reg == PAUSE);
    do_clear    = edit_state && stop_ev;
    do_shift    = edit_state && !stop_ev && key_ev;
    // A digit entered in the same cycle as start counts toward the nonzero check.
    new_nonzero = do_shift ? ((secs_tens_bcd != 4'd0) || (secs_ones_bcd != 4'd0) ||
                              (key_digit != 4'd0))
                           : !zero;
    go_cook     = edit_state && !stop_ev && start_ev && door_closed && new_nonzero;
    pause_now   = (state_reg == COOK) && (!door_closed || stop_ev);
    do_dec      = (state_reg == COOK) && !pause_now && tick_1hz;
    finish      = do_dec && one_left;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg   <= IDLE;
      mag_on_reg  <= 1'b0;
      done_reg    <= 1'b0;
      startn_prev <= 1'b1;
      stopn_prev  <= 1'b1;
      keypad_prev <= 10'd0;
    end else begin
      startn_prev <= startn;
      stopn_prev  <= stopn;
      keypad_prev <= keypad;
      mag_on_reg  <= 1'b0;
      done_reg    <= 1'b0;
      case (state_reg)
        IDLE, ENTRY, PAUSE: begin
          if (stop_ev) begin
            state_reg <= IDLE;
          end else if (go_cook) begin
            state_reg  <= COOK;
            mag_on_reg <= 1'b1;
          end else if (key_ev) begin
            state_reg <= ENTRY;
          end
        end
        COOK: begin
          if (pause_now) begin
            state_reg <= PAUSE;
          end else if (finish) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            mag_on_reg <= 1'b1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  bcd_timer3 u_timer (
    .clock      (clock),
    .clear      (clear),
    .load_zero  (do_clear),
    .shift_en   (do_shift),
    .digit      (key_digit),
    .dec_en     (do_dec),
    .min_digit  (min_bcd),
    .tens_digit (secs_tens_bcd),
    .ones_digit (secs_ones_bcd),
    .zero       (zero),
    .one_left   (one_left)
  );

  assign mag_on = mag_on_reg;
  assign done   = done_reg;
  assign state  = state_reg;

endmodule

// File: tb/tb_microwave_controller.sv
// Cycle-by-cycle vector bench for microwave_controller with a queue scoreboard.
module tb_microwave_controller;

  localparam logic [2:0] S_I = 3'd0, S_E = 3'd1, S_C = 3'd2, S_P = 3'd3, S_D = 3'd4;
  localparam logic [9:0] NK = 10'd0;

  typedef struct {
    logic       clr;
    logic       tick;
    logic [9:0] kp;
    logic       sn;
    logic       pn;
    logic       door;
    logic [2:0] st;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       mag;
    logic       dn;
  } vec_t;

  logic       clock;
  logic       clear;
  logic       tick_1hz;
  logic [9:0] keypad;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic [3:0] min_bcd;
  logic [3:0] secs_tens_bcd;
  logic [3:0] secs_ones_bcd;
  logic       mag_on;
  logic       done;
  logic [2:0] state;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks;
  int   n_fail;

  microwave_controller dut (
    .clock         (clock),
    .clear         (clear),
    .tick_1hz      (tick_1hz),
    .keypad        (keypad),
    .startn        (startn),
    .stopn         (stopn),
    .door_closed   (door_closed),
    .min_bcd       (min_bcd),
    .secs_tens_bcd (secs_tens_bcd),
    .secs_ones_bcd (secs_ones_bcd),
    .mag_on        (mag_on),
    .done          (done),
    .state         (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [9:0] k(input int d);
    logic [9:0] one;
    one = 10'd1;
    return one << d;
  endfunction

  task automatic add(input logic clr, input logic tick, input logic [9:0] kp,
                     input logic sn, input logic pn, input logic door,
                     input logic [2:0] st, input logic [3:0] m, input logic [3:0] t,
                     input logic [3:0] o, input logic mag, input logic dn);
    vec_t v;
    v.clr = clr; v.tick = tick; v.kp = kp; v.sn = sn; v.pn = pn; v.door = door;
    v.st = st; v.m = m; v.t = t; v.o = o; v.mag = mag; v.dn = dn;
    vecs.push_back(v);
  endtask

  task automatic check(input int row, input string what, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL row%0d %s: got %0d, expected %0d", row, what, got, want);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    clear = 1'b1; tick_1hz = 1'b0; keypad = 10'd0;
    startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;

    //   clr tick kp     sn pn door  state m t o  mag done
    add(1, 0, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);   // reset
    // keys 2,5,9 then start and three ticks
    add(0, 0, k(2), 1, 1, 1, S_E, 0, 0, 2, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 0, 0, 2, 0, 0);
    add(0, 0, k(5), 1, 1, 1, S_E, 0, 2, 5, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 0, 2, 5, 0, 0);
    add(0, 0, k(9), 1, 1, 1, S_E, 2, 5, 9, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 2, 5, 9, 0, 0);
    add(0, 0, NK,   0, 1, 1, S_C, 2, 5, 9, 1, 0);
    add(0, 1, NK,   1, 1, 1, S_C, 2, 5, 8, 1, 0);
    add(0, 1, NK,   1, 1, 1, S_C, 2, 5, 7, 1, 0);
    add(0, 1, NK,   1, 1, 1, S_C, 2, 5, 6, 1, 0);
    add(0, 0, NK,   1, 0, 1, S_P, 2, 5, 6, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_P, 2, 5, 6, 0, 0);
    add(0, 0, NK,   1, 0, 1, S_I, 0, 0, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);
    // 1:00 with the door open: start ignored
    add(0, 0, k(1), 1, 1, 0, S_E, 0, 0, 1, 0, 0);
    add(0, 0, NK,   1, 1, 0, S_E, 0, 0, 1, 0, 0);
    add(0, 0, k(0), 1, 1, 0, S_E, 0, 1, 0, 0, 0);
    add(0, 0, NK,   1, 1, 0, S_E, 0, 1, 0, 0, 0);
    add(0, 0, k(0), 1, 1, 0, S_E, 1, 0, 0, 0, 0);
    add(0, 0, NK,   1, 1, 0, S_E, 1, 0, 0, 0, 0);
    add(0, 0, NK,   0, 1, 0, S_E, 1, 0, 0, 0, 0);
    add(0, 0, NK,   1, 1, 0, S_E, 1, 0, 0, 0, 0);
    add(0, 0, NK,   1, 0, 1, S_I, 0, 0, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);
    // 0:01, cook, one tick -> DONE for one cycle -> IDLE
    add(0, 0, k(1), 1, 1, 1, S_E, 0, 0, 1, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 0, 0, 1, 0, 0);
    add(0, 0, NK,   0, 1, 1, S_C, 0, 0, 1, 1, 0);
    add(0, 0, NK,   1, 1, 1, S_C, 0, 0, 1, 1, 0);
    add(0, 1, NK,   1, 1, 1, S_D, 0, 0, 0, 0, 1);
    add(0, 0, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);
    // start at 0:00 ignored
    add(0, 0, NK,   0, 1, 1, S_I, 0, 0, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);
    // 1:30, door opens with a tick, close, resume
    add(0, 0, k(1), 1, 1, 1, S_E, 0, 0, 1, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 0, 0, 1, 0, 0);
    add(0, 0, k(3), 1, 1, 1, S_E, 0, 1, 3, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 0, 1, 3, 0, 0);
    add(0, 0, k(0), 1, 1, 1, S_E, 1, 3, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 1, 3, 0, 0, 0);
    add(0, 0, NK,   0, 1, 1, S_C, 1, 3, 0, 1, 0);
    add(0, 0, NK,   1, 1, 1, S_C, 1, 3, 0, 1, 0);
    add(0, 1, NK,   1, 1, 0, S_P, 1, 3, 0, 0, 0);
    add(0, 0, NK,   1, 1, 0, S_P, 1, 3, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_P, 1, 3, 0, 0, 0);
    add(0, 0, NK,   0, 1, 1, S_C, 1, 3, 0, 1, 0);
    add(0, 1, NK,   1, 1, 1, S_C, 1, 2, 9, 1, 0);
    add(0, 1, NK,   1, 1, 1, S_C, 1, 2, 8, 1, 0);
    add(0, 0, NK,   1, 0, 1, S_P, 1, 2, 8, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_P, 1, 2, 8, 0, 0);
    add(0, 0, NK,   1, 0, 1, S_I, 0, 0, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);
    // 0:45, stop twice (first press coincides with a tick)
    add(0, 0, k(4), 1, 1, 1, S_E, 0, 0, 4, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 0, 0, 4, 0, 0);
    add(0, 0, k(5), 1, 1, 1, S_E, 0, 4, 5, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 0, 4, 5, 0, 0);
    add(0, 0, NK,   0, 1, 1, S_C, 0, 4, 5, 1, 0);
    add(0, 0, NK,   1, 1, 1, S_C, 0, 4, 5, 1, 0);
    add(0, 1, NK,   1, 0, 1, S_P, 0, 4, 5, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_P, 0, 4, 5, 0, 0);
    add(0, 0, NK,   1, 0, 1, S_I, 0, 0, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);
    // key+start together, then minute borrow, then stop+start together
    add(0, 0, k(1), 1, 1, 1, S_E, 0, 0, 1, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 0, 0, 1, 0, 0);
    add(0, 0, k(0), 1, 1, 1, S_E, 0, 1, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 0, 1, 0, 0, 0);
    add(0, 0, k(0), 0, 1, 1, S_C, 1, 0, 0, 1, 0);
    add(0, 1, NK,   1, 1, 1, S_C, 0, 5, 9, 1, 0);
    add(0, 0, NK,   1, 0, 1, S_P, 0, 5, 9, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_P, 0, 5, 9, 0, 0);
    add(0, 0, NK,   0, 0, 1, S_I, 0, 0, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);
    // non-one-hot ignored, held key ignored, tens digit above 5 kept
    add(0, 0, 10'h006, 1, 1, 1, S_I, 0, 0, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);
    add(0, 0, k(7), 1, 1, 1, S_E, 0, 0, 7, 0, 0);
    add(0, 0, k(7), 1, 1, 1, S_E, 0, 0, 7, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 0, 0, 7, 0, 0);
    add(0, 0, k(8), 1, 1, 1, S_E, 0, 7, 8, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_E, 0, 7, 8, 0, 0);
    // clear mid-COOK together with a tick
    add(0, 0, NK,   0, 1, 1, S_C, 0, 7, 8, 1, 0);
    add(0, 0, NK,   1, 1, 1, S_C, 0, 7, 8, 1, 0);
    add(1, 1, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);
    add(0, 0, NK,   1, 1, 1, S_I, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      @(negedge clock);
      clear       = vecs[i].clr;
      tick_1hz    = vecs[i].tick;
      keypad      = vecs[i].kp;
      startn      = vecs[i].sn;
      stopn       = vecs[i].pn;
      door_closed = vecs[i].door;
      exp_q.push_back(vecs[i]);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check(i, "state", int'(state), int'(e.st));
      check(i, "time", int'({min_bcd, secs_tens_bcd, secs_ones_bcd}), int'({e.m, e.t, e.o}));
      check(i, "mag_on", int'(mag_on), int'(e.mag));
      check(i, "done", int'(done), int'(e.dn));
      $display("row%0d: state=%0d time=%0d:%0d%0d mag_on=%0b done=%0b", i, state,
               min_bcd, secs_tens_bcd, secs_ones_bcd, mag_on, done);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
